// File: rtl/rect_pulse_meter.sv
// Measures delay, high time, low time and period (in clk cycles) of a
// synchronised rectangular input, single-shot or continuously.
module rect_pulse_meter #(
    parameter int CNT_W       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sig_in,
    input  logic             arm,
    input  logic             cont,
    input  logic             stop,
    output logic             busy,
    output logic             meas_valid,
    output logic [CNT_W-1:0] td,
    output logic [CNT_W-1:0] th,
    output logic [CNT_W-1:0] tl,
    output logic [CNT_W:0]   period,
    output logic             sat
);

    // state     | meaning
    // IDLE      | waiting for arm; outputs hold the last result
    // WAIT_RISE | counting delay until the first true rising edge
    // HIGH      | counting high time until the falling edge
    // LOW       | counting low time until the rising edge closing the period
    typedef enum logic [1:0] {IDLE, WAIT_RISE, HIGH, LOW} state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s_d_q;
    logic                   s;
    logic                   rise;
    logic                   fall;

    state_t            state_q, state_d;
    logic              cont_q, cont_d;
    logic              first_q, first_d;
    logic [CNT_W-1:0]  td_cnt_q, td_cnt_d;
    logic [CNT_W-1:0]  hi_cnt_q, hi_cnt_d;
    logic [CNT_W-1:0]  lo_cnt_q, lo_cnt_d;
    logic [CNT_W-1:0]  td_hold_q, td_hold_d;
    logic [CNT_W-1:0]  th_hold_q, th_hold_d;
    logic              td_sat_q, td_sat_d;
    logic              hi_sat_q, hi_sat_d;
    logic              lo_sat_q, lo_sat_d;
    logic              th_sat_q, th_sat_d;
    logic [CNT_W-1:0]  td_q, td_d;
    logic [CNT_W-1:0]  th_q, th_d;
    logic [CNT_W-1:0]  tl_q, tl_d;
    logic [CNT_W:0]    period_q, period_d;
    logic              sat_q, sat_d;
    logic              valid_q, valid_d;

    assign s    = sync_q[SYNC_STAGES-1];
    assign rise = s & ~s_d_q;
    assign fall = ~s & s_d_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            s_d_q  <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], sig_in};
            s_d_q  <= s;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cont_q    <= 1'b0;
            first_q   <= 1'b0;
            td_cnt_q  <= '0;
            hi_cnt_q  <= '0;
            lo_cnt_q  <= '0;
            td_hold_q <= '0;
            th_hold_q <= '0;
            td_sat_q  <= 1'b0;
            hi_sat_q  <= 1'b0;
            lo_sat_q  <= 1'b0;
            th_sat_q  <= 1'b0;
            td_q      <= '0;
            th_q      <= '0;
            tl_q      <= '0;
            period_q  <= '0;
            sat_q     <= 1'b0;
            valid_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cont_q    <= cont_d;
            first_q   <= first_d;
            td_cnt_q  <= td_cnt_d;
            hi_cnt_q  <= hi_cnt_d;
            lo_cnt_q  <= lo_cnt_d;
            td_hold_q <= td_hold_d;
            th_hold_q <= th_hold_d;
            td_sat_q  <= td_sat_d;
            hi_sat_q  <= hi_sat_d;
            lo_sat_q  <= lo_sat_d;
            th_sat_q  <= th_sat_d;
            td_q      <= td_d;
            th_q      <= th_d;
            tl_q      <= tl_d;
            period_q  <= period_d;
            sat_q     <= sat_d;
            valid_q   <= valid_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cont_d    = cont_q;
        first_d   = first_q;
        td_cnt_d  = td_cnt_q;
        hi_cnt_d  = hi_cnt_q;
        lo_cnt_d  = lo_cnt_q;
        td_hold_d = td_hold_q;
        th_hold_d = th_hold_q;
        td_sat_d  = td_sat_q;
        hi_sat_d  = hi_sat_q;
        lo_sat_d  = lo_sat_q;
        th_sat_d  = th_sat_q;
        td_d      = td_q;
        th_d      = th_q;
        tl_d      = tl_q;
        period_d  = period_q;
        sat_d     = sat_q;
        valid_d   = 1'b0;

        if (stop) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (arm) begin
                        state_d   = WAIT_RISE;
                        cont_d    = cont;
                        first_d   = 1'b1;
                        td_cnt_d  = '0;
                        th_hold_d = '0;
                        td_sat_d  = 1'b0;
                        hi_sat_d  = 1'b0;
                        lo_sat_d  = 1'b0;
                        th_sat_d  = 1'b0;
                    end
                end
                WAIT_RISE: begin
                    if (rise) begin
                        td_hold_d = td_cnt_q;
                        hi_cnt_d  = CNT_ONE;
                        hi_sat_d  = 1'b0;
                        state_d   = HIGH;
                    end else begin
                        // Skipping the first cycle cancels the detector's extra cycle of latency.
                        first_d = 1'b0;
                        if (!first_q) begin
                            if (td_cnt_q == CNT_MAX) td_sat_d = 1'b1;
                            else                     td_cnt_d = td_cnt_q + CNT_ONE;
                        end
                    end
                end
                HIGH: begin
                    if (fall) begin
                        th_hold_d = hi_cnt_q;
                        th_sat_d  = hi_sat_q;
                        lo_cnt_d  = CNT_ONE;
                        lo_sat_d  = 1'b0;
                        state_d   = LOW;
                    end else if (hi_cnt_q == CNT_MAX) begin
                        hi_sat_d = 1'b1;
                    end else begin
                        hi_cnt_d = hi_cnt_q + CNT_ONE;
                    end
                end
                LOW: begin
                    if (rise) begin
                        valid_d  = 1'b1;
                        td_d     = td_hold_q;
                        th_d     = th_hold_q;
                        tl_d     = lo_cnt_q;
                        period_d = {1'b0, th_hold_q} + {1'b0, lo_cnt_q};
                        sat_d    = td_sat_q | th_sat_q | lo_sat_q;
                        th_sat_d = 1'b0;
                        lo_sat_d = 1'b0;
                        if (cont_q) begin
                            hi_cnt_d = CNT_ONE;
                            hi_sat_d = 1'b0;
                            state_d  = HIGH;
                        end else begin
                            state_d = IDLE;
                        end
                    end else if (lo_cnt_q == CNT_MAX) begin
                        lo_sat_d = 1'b1;
                    end else begin
                        lo_cnt_d = lo_cnt_q + CNT_ONE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign busy       = (state_q != IDLE);
    assign meas_valid = valid_q;
    assign td         = td_q;
    assign th         = th_q;
    assign tl         = tl_q;
    assign period     = period_q;
    assign sat        = sat_q;

endmodule

// File: tb/tb_rect_pulse_meter.sv
// Scoreboard bench for rect_pulse_meter: a 16-bit and a 4-bit instance share
// one stimulus; expected results are queued at stimulus time and popped on strobes.
module tb_rect_pulse_meter;

    typedef struct {
        int td;
        int th;
        int tl;
        bit bz;
    } raw_t;

    logic clk, rst_n, sig_in, arm, cont, stop;

    logic        busy16, mv16, sat16;
    logic [15:0] td16, th16, tl16;
    logic [16:0] per16;
    logic        busy4, mv4, sat4;
    logic [3:0]  td4, th4, tl4;
    logic [4:0]  per4;

    int   n_assert = 0;
    int   n_fail   = 0;
    int   n_strobe16 = 0;
    int   cyc = 0;
    int   last_cyc = 0;
    bit   have_last = 0;
    bit   space_chk = 0;
    raw_t q16[$];
    raw_t q4[$];
    raw_t last16, last4, r16, r4, zero_r;

    rect_pulse_meter #(.CNT_W(16), .SYNC_STAGES(2)) u_dut16 (
        .clk(clk), .rst_n(rst_n), .sig_in(sig_in), .arm(arm), .cont(cont), .stop(stop),
        .busy(busy16), .meas_valid(mv16), .td(td16), .th(th16), .tl(tl16),
        .period(per16), .sat(sat16)
    );

    rect_pulse_meter #(.CNT_W(4), .SYNC_STAGES(2)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .sig_in(sig_in), .arm(arm), .cont(cont), .stop(stop),
        .busy(busy4), .meas_valid(mv4), .td(td4), .th(th4), .tl(tl4),
        .period(per4), .sat(sat4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int clip(input int v, input int w);
        int mx;
        mx = (1 << w) - 1;
        return (v > mx) ? mx : v;
    endfunction

    task automatic chk_res(input string nm, input int w, input raw_t r,
                           input logic [31:0] otd, input logic [31:0] oth,
                           input logic [31:0] otl, input logic [31:0] oper,
                           input logic osat);
        int  mx;
        logic esat;
        mx   = (1 << w) - 1;
        esat = (r.td > mx) || (r.th > mx) || (r.tl > mx);
        check({nm, ".td"}, otd, clip(r.td, w));
        check({nm, ".th"}, oth, clip(r.th, w));
        check({nm, ".tl"}, otl, clip(r.tl, w));
        check({nm, ".period"}, oper, clip(r.th, w) + clip(r.tl, w));
        check({nm, ".sat"}, osat, esat);
    endtask

    always @(negedge clk) begin
        if (!space_chk) have_last = 0;
        if (rst_n && mv16) begin
            n_strobe16++;
            check("strobe16_expected", q16.size() > 0, 1);
            if (q16.size() > 0) begin
                r16    = q16.pop_front();
                last16 = r16;
                chk_res("res16", 16, r16, td16, th16, tl16, per16, sat16);
                check("busy16_at_strobe", busy16, r16.bz);
            end
            if (space_chk) begin
                if (have_last) check("strobe_spacing", cyc - last_cyc, 8);
                have_last = 1;
                last_cyc  = cyc;
            end
        end
        if (rst_n && mv4) begin
            check("strobe4_expected", q4.size() > 0, 1);
            if (q4.size() > 0) begin
                r4    = q4.pop_front();
                last4 = r4;
                chk_res("res4", 4, r4, td4, th4, tl4, per4, sat4);
            end
        end
    end

    task automatic hold(input logic v, input int n);
        sig_in = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic arm_go(input logic c);
        arm  = 1'b1;
        cont = c;
        @(negedge clk);
        arm  = 1'b0;
        cont = 1'b0;
        check("busy_after_arm", busy16, 1);
    endtask

    task automatic stop_pulse();
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        check("busy16_after_stop", busy16, 0);
        check("busy4_after_stop", busy4, 0);
    endtask

    task automatic push(input int a, input int b, input int c, input bit bz);
        raw_t r;
        r.td = a;
        r.th = b;
        r.tl = c;
        r.bz = bz;
        q16.push_back(r);
        q4.push_back(r);
    endtask

    task automatic settle(input string nm);
        repeat (3) @(negedge clk);
        check({nm, ".pending16"}, q16.size(), 0);
        check({nm, ".pending4"}, q4.size(), 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        zero_r = '{0, 0, 0, 0};
        rst_n = 1'b1; sig_in = 1'b0; arm = 1'b0; cont = 1'b0; stop = 1'b0;
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk_res("reset16", 16, zero_r, td16, th16, tl16, per16, sat16);
        chk_res("reset4", 4, zero_r, td4, th4, tl4, per4, sat4);
        check("reset.busy", busy16, 0);
        check("reset.valid", mv16, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // single-shot 6/5/3, with a stray arm (cont=1) while busy
        base = n_strobe16;
        arm_go(1'b0);
        hold(1'b0, 5);
        sig_in = 1'b1;
        @(negedge clk);
        arm = 1'b1; cont = 1'b1;
        @(negedge clk);
        arm = 1'b0; cont = 1'b0;
        repeat (3) @(negedge clk);
        hold(1'b0, 3);
        push(6, 5, 3, 0);
        hold(1'b1, 6);
        check("single.busy_after", busy16, 0);
        settle("single");
        check("single.strobes", n_strobe16 - base, 1);

        // continuous 4/4 for 10 periods
        hold(1'b0, 4);
        base = n_strobe16;
        arm_go(1'b1);
        hold(1'b0, 2);
        space_chk = 1;
        for (int i = 0; i < 10; i++) begin
            hold(1'b1, 4);
            hold(1'b0, 4);
            push(3, 4, 4, 1);
        end
        hold(1'b1, 4);
        stop_pulse();
        space_chk = 0;
        settle("cont");
        check("cont.strobes", n_strobe16 - base, 10);

        // stop in HIGH: no strobe, outputs unchanged
        base = n_strobe16;
        hold(1'b0, 3);
        arm_go(1'b0);
        hold(1'b0, 2);
        hold(1'b1, 3);
        check("stop.busy_before", busy16, 1);
        stop_pulse();
        chk_res("stop16", 16, last16, td16, th16, tl16, per16, sat16);
        chk_res("stop4", 4, last4, td4, th4, tl4, per4, sat4);
        hold(1'b0, 3);
        hold(1'b1, 4);
        hold(1'b0, 3);
        hold(1'b1, 4);
        settle("stop");
        check("stop.strobes", n_strobe16 - base, 0);

        // input already high at arm: td runs to the later true rise
        hold(1'b1, 3);
        arm_go(1'b0);
        hold(1'b1, 3);
        hold(1'b0, 5);
        hold(1'b1, 4);
        hold(1'b0, 2);
        push(9, 4, 2, 0);
        hold(1'b1, 6);
        settle("high_at_arm");
        check("high_at_arm.busy", busy16, 0);

        // saturation on the 4-bit instance, then a clean 3/3 period
        hold(1'b0, 3);
        arm_go(1'b1);
        hold(1'b0, 2);
        hold(1'b1, 20);
        hold(1'b0, 2);
        push(3, 20, 2, 1);
        hold(1'b1, 3);
        hold(1'b0, 3);
        push(3, 3, 3, 1);
        hold(1'b1, 3);
        stop_pulse();
        settle("sat");

        // reset while in LOW
        base = n_strobe16;
        hold(1'b0, 3);
        arm_go(1'b0);
        hold(1'b0, 1);
        hold(1'b1, 3);
        hold(1'b0, 3);
        check("rst.busy_before", busy16, 1);
        rst_n = 1'b0;
        #1;
        chk_res("rst16", 16, zero_r, td16, th16, tl16, per16, sat16);
        chk_res("rst4", 4, zero_r, td4, th4, tl4, per4, sat4);
        check("rst.busy", busy16, 0);
        check("rst.valid", mv16, 0);
        @(negedge clk);
        rst_n = 1'b1;
        hold(1'b1, 6);
        hold(1'b0, 4);
        hold(1'b1, 6);
        settle("rst");
        check("rst.strobes", n_strobe16 - base, 0);
        check("rst.busy_after", busy16, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/rect_pulse_meter.md
# rect_pulse_meter

Clocked measurement block that is the receiving end of the team's pulse/rectangle stimulus sources: where those generate a waveform from delay, high time, low time and period, this block recovers the same figures, in clock cycles, from a digital signal. It sits behind a comparator on the node driven by a rectangular or pulse source. It reports delay `td`, high time `th`, low time `tl` and `period` per complete cycle, in single-shot or continuous mode.

## Interface
Parameters:
- `CNT_W`, 16: width of the `td`/`th`/`tl` counters and outputs.
- `SYNC_STAGES`, 2: flops in the `sig_in` synchroniser (≥2).

Ports:
- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `sig_in`  in  1  asynchronous signal under measurement.
- `arm`  in  1  starts a measurement when sampled high in IDLE.
- `cont`  in  1  sampled with `arm`; 1 = continuous, 0 = single-shot.
- `stop`  in  1  abort to IDLE; priority over everything but reset.
- `busy`  out  1  high whenever state ≠ IDLE.
- `meas_valid`  out  1  one-cycle strobe; result outputs updated same cycle.
- `td`  out  CNT_W  cycles from arm to first rising edge.
- `th`  out  CNT_W  high time.
- `tl`  out  CNT_W  low time.
- `period`  out  CNT_W+1  `th`+`tl`, full width, no wrap.
- `sat`  out  1  a counter contributing to this result saturated.

## Operation
- Synchroniser: `sig_in` passes `SYNC_STAGES` flops to `s`; `s_d` is `s` delayed one cycle. `rise` = `s & ~s_d`, `fall` = `~s & s_d`.
- States: IDLE, WAIT_RISE, HIGH, LOW.
- IDLE: `arm`=1 → WAIT_RISE; latch `cont`; clear `td_cnt`, the internal saturation flags and the held `th`. Outputs keep their previous values.
- WAIT_RISE: `td_cnt` increments each cycle. On `rise`, capture `td_cnt` into a held `td` value, set `hi_cnt`=1 and go to HIGH. If `sig_in` is already high at arm, wait for the next true rising edge.
- HIGH: `hi_cnt`++ each cycle. On `fall`, capture `th` = `hi_cnt`, set `lo_cnt`=1 and go to LOW.
- LOW: `lo_cnt`++ each cycle. On `rise`, the next cycle drives `tl` = `lo_cnt`, `period` = `th`+`lo_cnt`, the held `td` and the held `th` onto the outputs, pulses `meas_valid` and sets `sat`. Then:
  - continuous: go to HIGH with `hi_cnt`=1. The rising edge that closes one period opens the next; no edges are lost.
  - single-shot: go to IDLE.
- In continuous mode `td` stays at the value from the first period.
- Saturation: every counter stops at 2^CNT_W−1 and never wraps. `sat` on a result = OR of the saturation flags of `td`, `th` and `tl` for that result. The flags clear at arm and after each `meas_valid`, except that the `td` flag persists for the whole continuous run.
- A stuck input holds the state, with its counter saturated, until `stop`.
- `stop` while busy → IDLE next cycle; the partial measurement is discarded and no `meas_valid` is issued.
- `arm` while busy is ignored.
- Reset mid-operation: everything returns to reset values immediately (asynchronous); no strobe follows.

## Timing
- Reset values:
  - state IDLE, `busy` 0, `meas_valid` 0, `td`/`th`/`tl`/`period` 0, `sat` 0.
  - All synchroniser flops and `s_d` are 0.
- Edge latency: a `sig_in` transition first sampled at cycle k is detected at cycle k+SYNC_STAGES−1.
- Arm sampled at cycle 0 and `sig_in` first sampled high at cycle k gives `td` = k+SYNC_STAGES−2 (= k for the default).
- Widths: a level held for N samples measures N.
- Result latency: `meas_valid` is asserted one cycle after the `rise` that closes the period. It never repeats without a new period.
- `busy` goes high the cycle after arm is sampled. In single-shot mode it falls in the same cycle as `meas_valid`.

## Test plan
- Single-shot: arm at cycle 0; `sig_in` rises at cycle 6, stays high 5 cycles, low 3, rises again → exactly one `meas_valid` with `td`=6, `th`=5, `tl`=3, `period`=8, `sat`=0; `busy`=0 afterwards.
- Continuous, 4 high / 4 low for 10 periods → 10 strobes spaced 8 cycles apart, each `th`=4, `tl`=4, `period`=8; `td` constant.
- Saturation with `CNT_W`=4: high 20 cycles, low 2 → `th`=15, `tl`=2, `period`=17, `sat`=1. A following clean 3/3 period → `sat`=0.
- `sig_in` high at arm, falls at cycle 4, rises at cycle 9 → `td` counts to the cycle-9 rise, not to the level present at arm.
- `stop` asserted mid-HIGH → IDLE next cycle, no `meas_valid`, outputs unchanged; `arm` while busy has no effect.
- `rst_n` pulsed low during LOW → all outputs 0 immediately; no strobe after release until a new arm.
